// File: rtl/strobe_divider.sv
// Multi-channel rate generator: per-channel strobe and 50% phase from a run-time divisor,
// with shadowed divisor writes that commit only at a period boundary, sync, or while idle.
module strobe_divider #(
   parameter int CHANNELS    = 4,
   parameter int DIV_W       = 24,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 262144,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] ch_enable,
   input  logic                sync_all,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [DIV_W-1:0]    wr_div,
   output logic                wr_ack,
   output logic                wr_err,
   output logic [CHANNELS-1:0] strobe,
   output logic [CHANNELS-1:0] phase,
   output logic [CHANNELS-1:0] pending,
   output logic [CNT_W-1:0]    free_cnt
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0]    cnt_q    [CHANNELS];
   logic [DIV_W-1:0]    cnt_d    [CHANNELS];
   logic [DIV_W-1:0]    div_q    [CHANNELS];
   logic [DIV_W-1:0]    div_d    [CHANNELS];
   logic [DIV_W-1:0]    shadow_q [CHANNELS];
   logic [DIV_W-1:0]    shadow_d [CHANNELS];
   logic [CHANNELS-1:0] strobe_q, strobe_d;
   logic [CHANNELS-1:0] phase_q, phase_d;
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] commit;
   logic                wr_ack_q, wr_ack_d;
   logic                wr_err_q, wr_err_d;
   logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;
   logic                wr_valid;

   always_comb begin
      wr_valid   = int'(wr_ch) < CHANNELS;
      free_cnt_d = free_cnt_q + CNT_W'(1);
      wr_ack_d   = wr_en && wr_valid;
      wr_err_d   = wr_en && !wr_valid;
      commit     = '0;
      strobe_d   = '0;
      phase_d    = phase_q;
      pending_d  = pending_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]    = cnt_q[i];
         div_d[i]    = div_q[i];
         shadow_d[i] = shadow_q[i];
         if (sync_all) begin
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
            commit[i]  = 1'b1;
         end else if (!ch_enable[i] || div_q[i] == '0) begin
            cnt_d[i]  = '0;
            commit[i] = 1'b1;
         end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
            cnt_d[i]    = '0;
            strobe_d[i] = 1'b1;
            phase_d[i]  = ~phase_q[i];
            commit[i]   = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
         end
         // Commit uses the old shadow; a same-cycle write lands in the shadow and stays pending.
         if (commit[i] && pending_q[i]) begin
            div_d[i]     = shadow_q[i];
            pending_d[i] = 1'b0;
         end
         if (wr_en && wr_valid && int'(wr_ch) == i) begin
            shadow_d[i]  = wr_div;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= '0;
            div_q[i]    <= DIV_RST;
            shadow_q[i] <= DIV_RST;
         end
         strobe_q   <= '0;
         phase_q    <= '0;
         pending_q  <= '0;
         wr_ack_q   <= 1'b0;
         wr_err_q   <= 1'b0;
         free_cnt_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= cnt_d[i];
            div_q[i]    <= div_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         strobe_q   <= strobe_d;
         phase_q    <= phase_d;
         pending_q  <= pending_d;
         wr_ack_q   <= wr_ack_d;
         wr_err_q   <= wr_err_d;
         free_cnt_q <= free_cnt_d;
      end
   end

   assign wr_ack   = wr_ack_q;
   assign wr_err   = wr_err_q;
   assign strobe   = strobe_q;
   assign phase    = phase_q;
   assign pending  = pending_q;
   assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_strobe_divider.sv
// Bench for strobe_divider: a 4-channel instance checked against a vector table, hand sequences
// and a countdown reference model; a 3-channel narrow instance covers wr_err and free_cnt wrap.
module tb_strobe_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: CHANNELS=4, DIV_W=8, CNT_W=32, DEFAULT_DIV=5
   logic        a_rst = 1'b1, a_sync = 1'b0, a_wr = 1'b0;
   logic [3:0]  a_en = '0;
   logic [1:0]  a_ch = '0;
   logic [7:0]  a_dv = '0;
   logic        a_ack, a_err;
   logic [3:0]  a_strobe, a_phase, a_pend;
   logic [31:0] a_free;

   strobe_divider #(.CHANNELS(4), .DIV_W(8), .CNT_W(32), .DEFAULT_DIV(5)) dut_a (
      .clk(clk), .rst(a_rst), .ch_enable(a_en), .sync_all(a_sync), .wr_en(a_wr),
      .wr_ch(a_ch), .wr_div(a_dv), .wr_ack(a_ack), .wr_err(a_err), .strobe(a_strobe),
      .phase(a_phase), .pending(a_pend), .free_cnt(a_free));

   // instance B: CHANNELS=3 (so wr_ch=3 is invalid), DIV_W=4, CNT_W=6 for a short wrap
   logic        b_rst = 1'b1, b_wr = 1'b0;
   logic [1:0]  b_ch = '0;
   logic [3:0]  b_dv = '0;
   logic        b_ack, b_err;
   logic [2:0]  b_strobe, b_phase, b_pend;
   logic [5:0]  b_free;

   strobe_divider #(.CHANNELS(3), .DIV_W(4), .CNT_W(6), .DEFAULT_DIV(5)) dut_b (
      .clk(clk), .rst(b_rst), .ch_enable(3'b111), .sync_all(1'b0), .wr_en(b_wr),
      .wr_ch(b_ch), .wr_div(b_dv), .wr_ack(b_ack), .wr_err(b_err), .strobe(b_strobe),
      .phase(b_phase), .pending(b_pend), .free_cnt(b_free));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each channel counts down the edges left until its next strobe.
   int          m_div [4], m_sh [4], m_left [4];
   logic [3:0]  m_str, m_ph, m_pend;
   logic        m_ack;
   logic [31:0] m_free;

   task automatic model_step(input logic r, input logic [3:0] en, input logic s,
                             input logic w, input logic [1:0] ch, input logic [7:0] dv);
      bit boundary;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_div[i] = 5; m_sh[i] = 5; m_left[i] = 5;
         end
         m_str = '0; m_ph = '0; m_pend = '0; m_ack = 1'b0; m_free = '0;
         return;
      end
      m_free = m_free + 32'd1;
      m_ack  = w;
      for (int i = 0; i < 4; i++) begin
         boundary = 1'b0;
         m_str[i] = 1'b0;
         if (s) begin
            m_ph[i]  = 1'b0;
            boundary = 1'b1;
         end else if (!en[i] || m_div[i] == 0) begin
            boundary = 1'b1;
         end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               m_str[i] = 1'b1;
               m_ph[i]  = ~m_ph[i];
               boundary = 1'b1;
            end
         end
         if (boundary) begin
            if (m_pend[i]) begin
               m_div[i]  = m_sh[i];
               m_pend[i] = 1'b0;
            end
            m_left[i] = m_div[i];
         end
         if (w && int'(ch) == i) begin
            m_sh[i]   = int'(dv);
            m_pend[i] = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic [3:0] en, input logic s,
                       input logic w, input logic [1:0] ch, input logic [7:0] dv);
      @(negedge clk);
      a_rst = r; a_en = en; a_sync = s; a_wr = w; a_ch = ch; a_dv = dv;
      model_step(r, en, s, w, ch, dv);
      @(posedge clk);
      #1;
      chk("strobe", 64'(a_strobe), 64'(m_str));
      chk("phase", 64'(a_phase), 64'(m_ph));
      chk("pending", 64'(a_pend), 64'(m_pend));
      chk("wr_ack", 64'(a_ack), 64'(m_ack));
      chk("wr_err", 64'(a_err), 64'd0);
      chk("free_cnt", 64'(a_free), 64'(m_free));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
   endtask

   task automatic b_step(input logic r, input logic w, input logic [1:0] ch, input logic [3:0] dv);
      @(negedge clk);
      b_rst = r; b_wr = w; b_ch = ch; b_dv = dv;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic       wr;
      logic [1:0] ch;
      logic [7:0] dv;
      logic [3:0] e_str, e_ph, e_pend;
      logic       e_ack;
   } vec_t;
   vec_t tbl [16];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] ph_frz;
      logic [3:0] r_en;

      // ---- instance B: invalid write and free_cnt wrap (A held in reset) ----
      b_step(1'b1, 1'b0, 2'd0, 4'd0);
      chk("b_reset_free", 64'(b_free), 64'd0);
      chk("b_reset_err", 64'(b_err), 64'd0);
      for (int k = 1; k <= 64; k++) begin
         b_step(1'b0, k == 2, 2'd3, 4'd2);
         chk($sformatf("b_err_%0d", k), 64'(b_err), 64'(k == 2));
         chk($sformatf("b_ack_%0d", k), 64'(b_ack), 64'd0);
         chk($sformatf("b_pend_%0d", k), 64'(b_pend), 64'd0);
         chk($sformatf("b_strobe_%0d", k), 64'(b_strobe), (k % 5 == 0) ? 64'h7 : 64'h0);
         chk($sformatf("b_free_%0d", k), 64'(b_free), 64'(k % 64));
      end

      // ---- instance A: vector table, all channels enabled, write ch1=3 at cnt=1 ----
      for (int k = 0; k < 16; k++)
         tbl[k] = '{rst: 1'b0, wr: 1'b0, ch: 2'd0, dv: 8'd0,
                    e_str: 4'h0, e_ph: 4'h0, e_pend: 4'h0, e_ack: 1'b0};
      tbl[0].rst = 1'b1;
      tbl[2].wr = 1'b1; tbl[2].ch = 2'd1; tbl[2].dv = 8'd3; tbl[2].e_ack = 1'b1;
      for (int k = 2; k <= 4; k++) tbl[k].e_pend = 4'b0010;
      tbl[5].e_str  = 4'b1111;
      tbl[8].e_str  = 4'b0010;
      tbl[10].e_str = 4'b1101;
      tbl[11].e_str = 4'b0010;
      tbl[14].e_str = 4'b0010;
      tbl[15].e_str = 4'b1101;
      for (int k = 5; k <= 7; k++)   tbl[k].e_ph = 4'b1111;
      for (int k = 8; k <= 9; k++)   tbl[k].e_ph = 4'b1101;
      for (int k = 11; k <= 13; k++) tbl[k].e_ph = 4'b0010;
      tbl[15].e_ph = 4'b1101;

      for (int k = 0; k < 16; k++) begin
         step(tbl[k].rst, 4'hF, 1'b0, tbl[k].wr, tbl[k].ch, tbl[k].dv);
         chk($sformatf("tbl_strobe_%0d", k), 64'(a_strobe), 64'(tbl[k].e_str));
         chk($sformatf("tbl_phase_%0d", k), 64'(a_phase), 64'(tbl[k].e_ph));
         chk($sformatf("tbl_pending_%0d", k), 64'(a_pend), 64'(tbl[k].e_pend));
         chk($sformatf("tbl_ack_%0d", k), 64'(a_ack), 64'(tbl[k].e_ack));
         chk($sformatf("tbl_free_%0d", k), 64'(a_free), 64'(k));
      end

      // ---- sync_all realigns ch0 (div 7) and ch2 (div 3) ----
      step(1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 8'd7);
      step(1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 8'd3);
      idle(3);
      step(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      chk("sync_phase", 64'(a_phase), 64'd0);
      chk("sync_strobe", 64'(a_strobe), 64'd0);
      chk("sync_pending", 64'(a_pend), 64'd0);
      for (int k = 1; k <= 7; k++) begin
         idle(1);
         chk($sformatf("sync_ch0_%0d", k), 64'(a_strobe[0]), 64'(k == 7));
         chk($sformatf("sync_ch2_%0d", k), 64'(a_strobe[2]), 64'(k == 3 || k == 6));
      end

      // ---- divisor 1 then divisor 0 on ch3 ----
      step(1'b0, 4'hF, 1'b0, 1'b1, 2'd3, 8'd1);
      step(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         chk($sformatf("div1_strobe_%0d", k), 64'(a_strobe[3]), 64'd1);
         chk($sformatf("div1_phase_%0d", k), 64'(a_phase[3]), 64'(k % 2));
      end
      step(1'b0, 4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
      idle(1);
      ph_frz = m_ph;
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         chk($sformatf("div0_strobe_%0d", k), 64'(a_strobe[3]), 64'd0);
         chk($sformatf("div0_phase_%0d", k), 64'(a_phase[3]), 64'(ph_frz[3]));
      end

      // ---- drop ch0 enable mid-count, restore: first strobe 7 edges later ----
      step(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
      idle(3);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 8'd0);
         chk($sformatf("dis_strobe_%0d", k), 64'(a_strobe[0]), 64'd0);
      end
      for (int k = 1; k <= 7; k++) begin
         idle(1);
         chk($sformatf("reen_ch0_%0d", k), 64'(a_strobe[0]), 64'(k == 7));
      end

      // ---- reset mid-period with a write pending and a write in flight ----
      step(1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 8'd9);
      step(1'b1, 4'hF, 1'b0, 1'b1, 2'd1, 8'd4);
      chk("rst_ack", 64'(a_ack), 64'd0);
      chk("rst_pending", 64'(a_pend), 64'd0);
      chk("rst_phase", 64'(a_phase), 64'd0);
      chk("rst_free", 64'(a_free), 64'd0);
      for (int k = 1; k <= 5; k++) begin
         idle(1);
         chk($sformatf("rst_default_%0d", k), 64'(a_strobe), (k == 5) ? 64'hF : 64'h0);
      end

      // ---- randomized traffic against the model ----
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 4; i++) r_en[i] = ($urandom_range(0, 9) != 0);
         step($urandom_range(0, 49) == 0, r_en, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
